md_seq: RTL and testbench



---
 rtl/md_pkg.sv | 50 +++++
 rtl/md_classify.sv | 28 ++
 rtl/md_seq.sv | 192 +++++++++++++++++++
 tb/tb_md_seq.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide sequencer.
// Holds the opcode/function encodings used by the engine, the operation
// class and FSM state encodings, and the fixed result words returned for
// divide-by-zero and timeout aborts.
package md_pkg;

    // Register-register opcode and the multiply/divide function codes under it
    localparam logic [8:0] OP_RR   = 9'h033;
    localparam logic [3:0] FN_MUL  = 4'h8;
    localparam logic [3:0] FN_MULS = 4'h9;
    localparam logic [3:0] FN_DIV  = 4'hA;
    localparam logic [3:0] FN_DIVS = 4'hB;
    localparam logic [3:0] FN_MOD  = 4'hC;
    localparam logic [3:0] FN_MODS = 4'hD;

    // Fixed result words
    localparam logic [31:0] DBZ_Q    = 32'hFFFF_FFFF;
    localparam logic [31:0] TMO_DATA = 32'hDEAD_DEAD;

    typedef enum logic [2:0] {
        CL_MUL     = 3'd0,
        CL_MULS    = 3'd1,
        CL_DIV     = 3'd2,
        CL_DIVS    = 3'd3,
        CL_MOD     = 3'd4,
        CL_MODS    = 3'd5,
        CL_ILLEGAL = 3'd7
    } op_class_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_WB     = 3'd3,
        ST_DRAIN  = 3'd4
    } md_state_e;

    function automatic logic cls_is_div(op_class_e c);
        return (c == CL_DIV) || (c == CL_DIVS);
    endfunction

    function automatic logic cls_is_mod(op_class_e c);
        return (c == CL_MOD) || (c == CL_MODS);
    endfunction

    function automatic logic cls_is_divmod(op_class_e c);
        return cls_is_div(c) || cls_is_mod(c);
    endfunction

endpackage

// File: rtl/md_classify.sv
// md_classify: combinational opcode/function -> operation class decoder.
// Shared between the sequencer and the execute-stage hazard logic so both
// agree on which instructions occupy the multiplier/divider.
module md_classify
    import md_pkg::*;
(
    input  logic [8:0] op,
    input  logic [3:0] fn,
    output op_class_e  cls
);

    // Anything outside the RR multiply/divide group is reported as illegal
    always_comb begin
        cls = CL_ILLEGAL;
        if (op == OP_RR) begin
            case (fn)
                FN_MUL:  cls = CL_MUL;
                FN_MULS: cls = CL_MULS;
                FN_DIV:  cls = CL_DIV;
                FN_DIVS: cls = CL_DIVS;
                FN_MOD:  cls = CL_MOD;
                FN_MODS: cls = CL_MODS;
                default: cls = CL_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/md_seq.sv
// md_seq: CPU-side initiator for the 32-bit multiplier/divider engine.
// Accepts one request from execute, launches the engine with a one-cycle
// md_ld pulse, waits for md_done, and holds the selected result on the
// writeback port until acknowledged. Divide-by-zero and illegal ops are
// answered without touching the engine; flush while the engine runs drains
// it silently; a stuck engine is abandoned after TIMEOUT cycles.
// Optional feature: define MD_MULH_EN to return md_p[63:32] for multiplies
// requested with req_hi=1 (otherwise the low half is always returned).
module md_seq
    import md_pkg::*;
#(
    parameter int TIMEOUT = 40,
    parameter int TGT_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic [8:0]       req_op,
    input  logic [3:0]       req_fn,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TGT_W-1:0] req_tgt,
    input  logic             req_hi,
    output logic             ready,
    input  logic             flush,
    output logic             md_ld,
    output logic [8:0]       md_op,
    output logic [3:0]       md_fn,
    output logic [31:0]      md_a,
    output logic [31:0]      md_b,
    input  logic [63:0]      md_p,
    input  logic [31:0]      md_q,
    input  logic [31:0]      md_r,
    input  logic             md_done,
    output logic             wb_vld,
    output logic [TGT_W-1:0] wb_tgt,
    output logic [31:0]      wb_data,
    input  logic             wb_ack,
    output logic             dbz,
    output logic             tmo
);

    localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    md_state_e        state;
    op_class_e        req_cls;
    op_class_e        cls_q;
    logic             hi_q;
    logic             guard;
    logic [CNT_W-1:0] cnt;
    logic             mulh_sel;

    md_classify u_classify (
        .op  (req_op),
        .fn  (req_fn),
        .cls (req_cls)
    );

`ifdef MD_MULH_EN
    assign mulh_sel = hi_q;
`else
    // Upper product half is never returned in this build
    logic unused_mulh;
    assign mulh_sel    = 1'b0;
    assign unused_mulh = hi_q;
`endif

    // Architectural result for the operation class that completed
    function automatic logic [31:0] sel_result(
        input op_class_e   c,
        input logic        hi,
        input logic [63:0] p,
        input logic [31:0] q,
        input logic [31:0] r
    );
        logic [31:0] res;
        case (c)
            CL_MUL, CL_MULS: res = hi ? p[63:32] : p[31:0];
            CL_DIV, CL_DIVS: res = q;
            CL_MOD, CL_MODS: res = r;
            default:         res = '0;
        endcase
        return res;
    endfunction

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ready   <= 1'b1;
            md_ld   <= 1'b0;
            wb_vld  <= 1'b0;
            dbz     <= 1'b0;
            tmo     <= 1'b0;
            wb_data <= '0;
            wb_tgt  <= '0;
            md_op   <= '0;
            md_fn   <= '0;
            md_a    <= '0;
            md_b    <= '0;
            cls_q   <= CL_ILLEGAL;
            hi_q    <= 1'b0;
            guard   <= 1'b0;
            cnt     <= '0;
        end else begin
            md_ld <= 1'b0;
            dbz   <= 1'b0;
            tmo   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // flush in the same cycle blocks acceptance
                    if (req && !flush) begin
                        md_op  <= req_op;
                        md_fn  <= req_fn;
                        md_a   <= req_a;
                        md_b   <= req_b;
                        wb_tgt <= req_tgt;
                        cls_q  <= req_cls;
                        hi_q   <= req_hi;
                        ready  <= 1'b0;
                        if (req_cls == CL_ILLEGAL) begin
                            state   <= ST_WB;
                            wb_vld  <= 1'b1;
                            wb_data <= '0;
                        end else if (cls_is_divmod(req_cls) && (req_b == '0)) begin
                            state   <= ST_WB;
                            wb_vld  <= 1'b1;
                            dbz     <= 1'b1;
                            wb_data <= cls_is_div(req_cls) ? DBZ_Q : req_a;
                        end else begin
                            state <= ST_LAUNCH;
                            md_ld <= 1'b1;
                        end
                    end
                end

                ST_LAUNCH: begin
                    // engine already loaded this cycle; it cannot be cancelled
                    cnt   <= '0;
                    guard <= 1'b1;
                    state <= flush ? ST_DRAIN : ST_WAIT;
                end

                ST_WAIT: begin
                    // md_done may still be stale in the first cycle after md_ld
                    guard <= 1'b0;
                    if (flush) begin
                        state <= ST_DRAIN;
                    end else if (md_done && !guard) begin
                        state   <= ST_WB;
                        wb_vld  <= 1'b1;
                        wb_data <= sel_result(cls_q, mulh_sel, md_p, md_q, md_r);
                    end else if (cnt == CNT_LAST) begin
                        state   <= ST_WB;
                        wb_vld  <= 1'b1;
                        wb_data <= TMO_DATA;
                        tmo     <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_WB: begin
                    if (flush || wb_ack) begin
                        state  <= ST_IDLE;
                        wb_vld <= 1'b0;
                        ready  <= 1'b1;
                    end
                end

                ST_DRAIN: begin
                    // no writeback and no tmo pulse on this path
                    guard <= 1'b0;
                    if ((md_done && !guard) || (cnt == CNT_LAST)) begin
                        state <= ST_IDLE;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state  <= ST_IDLE;
                    ready  <= 1'b1;
                    wb_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_seq.sv
// tb_md_seq: directed self-checking bench for md_seq with a small
// behavioural engine that keeps md_done stale for one cycle after md_ld.
module tb_md_seq;
    import md_pkg::*;

    localparam int TIMEOUT = 40;
    localparam int TGT_W   = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req = 1'b0;
    logic [8:0]       req_op = '0;
    logic [3:0]       req_fn = '0;
    logic [31:0]      req_a = '0;
    logic [31:0]      req_b = '0;
    logic [TGT_W-1:0] req_tgt = '0;
    logic             req_hi = 1'b0;
    logic             ready;
    logic             flush = 1'b0;
    logic             md_ld;
    logic [8:0]       md_op;
    logic [3:0]       md_fn;
    logic [31:0]      md_a;
    logic [31:0]      md_b;
    logic [63:0]      md_p = '0;
    logic [31:0]      md_q = '0;
    logic [31:0]      md_r = '0;
    logic             md_done = 1'b1;
    logic             wb_vld;
    logic [TGT_W-1:0] wb_tgt;
    logic [31:0]      wb_data;
    logic             wb_ack = 1'b0;
    logic             dbz;
    logic             tmo;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // engine model state
    int          ld_cnt = 0;
    int          ld_cyc = 0;
    int          eng_lat = 2;
    logic        eng_stuck = 1'b0;
    logic        eng_busy = 1'b0;
    logic        eng_lag = 1'b0;
    int          eng_cnt = 0;
    logic [31:0] e_a, e_b;
    logic [3:0]  e_fn;

    md_seq #(.TIMEOUT(TIMEOUT), .TGT_W(TGT_W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .req_fn(req_fn),
        .req_a(req_a), .req_b(req_b), .req_tgt(req_tgt), .req_hi(req_hi),
        .ready(ready), .flush(flush), .md_ld(md_ld), .md_op(md_op), .md_fn(md_fn),
        .md_a(md_a), .md_b(md_b), .md_p(md_p), .md_q(md_q), .md_r(md_r),
        .md_done(md_done), .wb_vld(wb_vld), .wb_tgt(wb_tgt), .wb_data(wb_data),
        .wb_ack(wb_ack), .dbz(dbz), .tmo(tmo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Engine: on md_ld, garbage results with done still high for one cycle,
    // then done low for eng_lat cycles, then real results with done high.
    always @(negedge clk) begin
        if (!rst_n) begin
            eng_busy = 1'b0;
            eng_lag  = 1'b0;
            md_done  = 1'b1;
        end else if (md_ld) begin
            ld_cnt++;
            ld_cyc   = cyc;
            e_a      = md_a;
            e_b      = md_b;
            e_fn     = md_fn;
            eng_busy = 1'b1;
            eng_lag  = 1'b1;
            eng_cnt  = eng_lat;
            md_p     = {2{32'h5A5A_5A5A}};
            md_q     = 32'hA5A5_A5A5;
            md_r     = 32'h3C3C_3C3C;
        end else if (eng_lag) begin
            eng_lag = 1'b0;
        end else if (eng_busy) begin
            md_done = 1'b0;
            if (!eng_stuck) begin
                if (eng_cnt == 0) begin
                    md_p = {32'b0, e_a} * {32'b0, e_b};
                    if (e_fn == FN_MULS)
                        md_p = $signed({{32{e_a[31]}}, e_a}) * $signed({{32{e_b[31]}}, e_b});
                    if (e_b == 0) begin
                        md_q = 32'hFFFF_FFFF;
                        md_r = e_a;
                    end else if (e_fn == FN_DIVS || e_fn == FN_MODS) begin
                        md_q = $signed(e_a) / $signed(e_b);
                        md_r = $signed(e_a) % $signed(e_b);
                    end else begin
                        md_q = e_a / e_b;
                        md_r = e_a % e_b;
                    end
                    md_done  = 1'b1;
                    eng_busy = 1'b0;
                end else begin
                    eng_cnt--;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [8:0] op, input logic [3:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [TGT_W-1:0] tgt, input logic hi);
        req = 1'b1; req_op = op; req_fn = fn; req_a = a; req_b = b;
        req_tgt = tgt; req_hi = hi;
        step();
        req = 1'b0;
    endtask

    task automatic wait_wb(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (wb_vld) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check_eq({tag, "_wb_seen"}, ok, 1'b1);
    endtask

    task automatic ack_wb(input string tag);
        wb_ack = 1'b1;
        step();
        wb_ack = 1'b0;
        check_eq({tag, "_ack_vld"}, wb_vld, 1'b0);
        check_eq({tag, "_ack_ready"}, ready, 1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int l0;
        logic prev_done, seen_wb, drained;

        // ---------------- reset state (req held high must not matter)
        req = 1'b1; req_op = OP_RR; req_fn = FN_DIV; req_a = 32'h1111; req_b = 32'h2;
        repeat (3) step();
        check_eq("rst_ready", ready, 1'b1);
        check_eq("rst_md_ld", md_ld, 1'b0);
        check_eq("rst_wb_vld", wb_vld, 1'b0);
        check_eq("rst_dbz", dbz, 1'b0);
        check_eq("rst_tmo", tmo, 1'b0);
        check_eq("rst_wb_data", wb_data, 32'h0);
        check_eq("rst_wb_tgt", wb_tgt, '0);
        check_eq("rst_md_a", md_a, 32'h0);
        check_eq("rst_md_op", md_op, 9'h0);
        req = 1'b0;
        rst_n = 1'b1;
        step();

        // ---------------- DIV 0x12345678 / 10
        l0 = ld_cnt;
        send(OP_RR, FN_DIV, 32'h1234_5678, 32'd10, 4'h5, 1'b0);
        check_eq("div_md_ld", md_ld, 1'b1);
        check_eq("div_md_a", md_a, 32'h1234_5678);
        check_eq("div_md_b", md_b, 32'd10);
        check_eq("div_md_fn", md_fn, FN_DIV);
        check_eq("div_ready_busy", ready, 1'b0);
        step();
        check_eq("div_ld_one_cycle", md_ld, 1'b0);
        wait_wb("div");
        check_eq("div_data", wb_data, 32'h01D2_08A5);
        check_eq("div_tgt", wb_tgt, 4'h5);
        check_eq("div_ld_count", ld_cnt - l0, 1);
        check_eq("div_dbz", dbz, 1'b0);
        ack_wb("div");

        // ---------------- MOD same operands
        send(OP_RR, FN_MOD, 32'h1234_5678, 32'd10, 4'hA, 1'b0);
        wait_wb("mod");
        check_eq("mod_data", wb_data, 32'd6);
        check_eq("mod_tgt", wb_tgt, 4'hA);
        ack_wb("mod");

        // ---------------- MULS -3 * 7, stale done in guard cycle
        send(OP_RR, FN_MULS, 32'hFFFF_FFFD, 32'd7, 4'h3, 1'b0);
        wait_wb("muls");
        check_eq("muls_data", wb_data, 32'hFFFF_FFEB);
        ack_wb("muls");

        // ---------------- DIV by zero: no launch, dbz pulse
        l0 = ld_cnt;
        send(OP_RR, FN_DIV, 32'd77, 32'd0, 4'h7, 1'b0);
        check_eq("dbz_wb_vld", wb_vld, 1'b1);
        check_eq("dbz_pulse", dbz, 1'b1);
        check_eq("dbz_data", wb_data, 32'hFFFF_FFFF);
        check_eq("dbz_tgt", wb_tgt, 4'h7);
        step();
        check_eq("dbz_one_cycle", dbz, 1'b0);
        check_eq("dbz_no_ld", ld_cnt - l0, 0);
        ack_wb("dbz");

        // ---------------- MOD by zero returns dividend
        send(OP_RR, FN_MOD, 32'd5, 32'd0, 4'h1, 1'b0);
        check_eq("modz_dbz", dbz, 1'b1);
        check_eq("modz_data", wb_data, 32'd5);
        ack_wb("modz");

        // ---------------- MUL upper half select
        send(OP_RR, FN_MUL, 32'h0001_0000, 32'h0001_0000, 4'h2, 1'b1);
        wait_wb("mulh");
`ifdef MD_MULH_EN
        check_eq("mulh_data", wb_data, 32'd1);
`else
        check_eq("mulh_data", wb_data, 32'd0);
`endif
        ack_wb("mulh");

        // ---------------- illegal op: immediate zero writeback
        l0 = ld_cnt;
        send(9'h013, FN_DIV, 32'd9, 32'd3, 4'hC, 1'b0);
        check_eq("ill_wb_vld", wb_vld, 1'b1);
        check_eq("ill_data", wb_data, 32'h0);
        check_eq("ill_tgt", wb_tgt, 4'hC);
        check_eq("ill_no_ld", ld_cnt - l0, 0);
        ack_wb("ill");

        // ---------------- flush in IDLE blocks acceptance
        l0 = ld_cnt;
        req = 1'b1; flush = 1'b1; req_op = OP_RR; req_fn = FN_DIV; req_a = 32'd8; req_b = 32'd0;
        step();
        req = 1'b0; flush = 1'b0;
        check_eq("fidle_ready", ready, 1'b1);
        check_eq("fidle_wb_vld", wb_vld, 1'b0);
        check_eq("fidle_dbz", dbz, 1'b0);
        step();
        check_eq("fidle_no_ld", ld_cnt - l0, 0);

        // ---------------- flush in WB drops writeback
        send(OP_RR, FN_DIV, 32'd8, 32'd0, 4'h4, 1'b0);
        check_eq("fwb_vld_before", wb_vld, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("fwb_vld_after", wb_vld, 1'b0);
        check_eq("fwb_ready", ready, 1'b1);

        // ---------------- flush two cycles after launch -> DRAIN
        eng_lat = 8;
        l0 = ld_cnt;
        send(OP_RR, FN_DIV, 32'd100, 32'd3, 4'h6, 1'b0);
        check_eq("drain_md_ld", md_ld, 1'b1);
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        seen_wb = 1'b0; drained = 1'b0; prev_done = md_done;
        for (int i = 0; i < 60; i++) begin
            if (wb_vld) seen_wb = 1'b1;
            if (ready) begin
                drained = 1'b1;
                break;
            end
            prev_done = md_done;
            step();
        end
        check_eq("drain_ready", drained, 1'b1);
        check_eq("drain_no_wb", seen_wb, 1'b0);
        check_eq("drain_after_done", prev_done, 1'b1);
        check_eq("drain_ld_count", ld_cnt - l0, 1);
        eng_lat = 2;
        send(OP_RR, FN_DIV, 32'h1234_5678, 32'd10, 4'h9, 1'b0);
        wait_wb("post_drain");
        check_eq("post_drain_data", wb_data, 32'h01D2_08A5);
        check_eq("post_drain_tgt", wb_tgt, 4'h9);
        ack_wb("post_drain");

        // ---------------- stuck engine -> timeout; WAIT lasts TIMEOUT cycles,
        // so tmo appears TIMEOUT+1 cycles after the md_ld cycle
        eng_stuck = 1'b1;
        send(OP_RR, FN_DIVS, 32'd100, 32'd7, 4'hE, 1'b0);
        wait_wb("tmo");
        check_eq("tmo_pulse", tmo, 1'b1);
        check_eq("tmo_data", wb_data, 32'hDEAD_DEAD);
        check_eq("tmo_tgt", wb_tgt, 4'hE);
        check_eq("tmo_latency", cyc - ld_cyc, TIMEOUT + 1);
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("hold_vld", wb_vld, 1'b1);
            check_eq("hold_data", wb_data, 32'hDEAD_DEAD);
            check_eq("hold_tgt", wb_tgt, 4'hE);
            check_eq("hold_tmo_low", tmo, 1'b0);
        end
        ack_wb("tmo");

        // ---------------- reset mid-operation abandons everything
        send(OP_RR, FN_MUL, 32'd3, 32'd4, 4'hB, 1'b0);
        step();
        step();
        rst_n = 1'b0;
        step();
        check_eq("midrst_ready", ready, 1'b1);
        check_eq("midrst_wb_vld", wb_vld, 1'b0);
        check_eq("midrst_md_a", md_a, 32'h0);
        rst_n = 1'b1;
        eng_stuck = 1'b0;
        step();
        step();
        check_eq("midrst_no_wb", wb_vld, 1'b0);
        send(OP_RR, FN_MUL, 32'd3, 32'd4, 4'hB, 1'b0);
        wait_wb("after_rst");
        check_eq("after_rst_data", wb_data, 32'd12);
        ack_wb("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
